// File: rtl/spi_responder.sv
`default_nettype none
// ============================================================================
//  Module      : spi_responder
//  Description : SPI mode-0 responder, oversampled by the system clock.
//                Synchronizes SCK/CS_n/MOSI, detects edges, and shifts
//                full-duplex bytes between the pins and a one-entry transmit
//                holding register / one-entry receive output register.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_responder #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    // SPI pins
    input  logic              spi_sck,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    // transmit side
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    // receive side
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    // status
    output logic              rx_overrun,
    output logic              tx_underrun,
    input  logic              status_clr,
    output logic              busy
);

    localparam int                 c_CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(DATA_W - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    // synchronizer chains plus one extra registered copy for edge detection
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sck_d;
    logic                   r_cs_d;

    logic                   w_sck_s;
    logic                   w_cs_s;
    logic                   w_mosi_s;
    logic                   w_sck_rise;
    logic                   w_sck_fall;
    logic                   w_cs_rise;
    logic                   w_cs_fall;

    // FSM decode
    logic                   w_frame_start;
    logic                   w_frame_end;
    logic                   w_shifting;
    logic                   w_busy;

    // datapath
    logic [c_CNT_W-1:0]     r_bit_cnt;
    logic                   r_boundary;
    logic [DATA_W-1:0]      r_rx_shift;
    logic [DATA_W-1:0]      r_tx_shift;
    logic [DATA_W-1:0]      r_hold;
    logic                   r_hold_full;
    logic [DATA_W-1:0]      r_rx_data;
    logic                   r_rx_valid;
    logic                   r_rx_overrun;
    logic                   r_tx_underrun;

    logic                   w_bit_rise;
    logic                   w_bit_fall;
    logic                   w_byte_done;
    logic                   w_load;
    logic [DATA_W-1:0]      w_rx_next;
    logic                   w_rx_accept;
    logic                   w_rx_drop;
    logic                   w_hold_wr;
    logic                   w_underrun_evt;

    assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
    assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
    assign w_sck_rise =  w_sck_s & ~r_sck_d;
    assign w_sck_fall = ~w_sck_s &  r_sck_d;
    assign w_cs_rise  =  w_cs_s  & ~r_cs_d;
    assign w_cs_fall  = ~w_cs_s  &  r_cs_d;

    // Pin synchronizers. CS resets to the "selected" level so that a CS
    // already low when reset releases never looks like a falling edge; a CS
    // that is high at release only produces a rising edge, ignored in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sck_sync  <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_sck_d     <= 1'b0;
            r_cs_d      <= 1'b0;
        end else begin
            r_sck_sync[0]  <= spi_sck;
            r_cs_sync[0]   <= spi_cs_n;
            r_mosi_sync[0] <= spi_mosi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sck_sync[i]  <= r_sck_sync[i-1];
                r_cs_sync[i]   <= r_cs_sync[i-1];
                r_mosi_sync[i] <= r_mosi_sync[i-1];
            end
            r_sck_d <= w_sck_s;
            r_cs_d  <= w_cs_s;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and frame-control decode; SCK edges only matter in SHIFT
    always_comb begin
        w_state_nxt   = r_state;
        w_frame_start = 1'b0;
        w_frame_end   = 1'b0;
        w_shifting    = 1'b0;
        w_busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt   = ST_SHIFT;
                    w_frame_start = 1'b1;
                end
            end
            ST_SHIFT: begin
                w_busy = 1'b1;
                if (w_cs_rise) begin
                    w_state_nxt = ST_IDLE;
                    w_frame_end = 1'b1;
                end else begin
                    w_shifting = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_bit_rise     = w_shifting & w_sck_rise;
    assign w_bit_fall     = w_shifting & w_sck_fall;
    assign w_byte_done    = w_bit_rise & (r_bit_cnt == c_LAST_BIT);
    assign w_load         = w_frame_start | (w_bit_fall & r_boundary);
    assign w_rx_next      = {r_rx_shift[DATA_W-2:0], w_mosi_s};
    assign w_rx_accept    = w_byte_done & (~r_rx_valid | rx_ready);
    assign w_rx_drop      = w_byte_done & ~w_rx_accept;
    assign w_hold_wr      = tx_valid & ~r_hold_full;
    assign w_underrun_evt = w_load & ~r_hold_full;

    // Receive shifter and bit counter; a frame start or end discards any
    // partial byte so a short frame never produces rx_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt  <= '0;
            r_boundary <= 1'b0;
            r_rx_shift <= '0;
        end else if (w_frame_start || w_frame_end) begin
            r_bit_cnt  <= '0;
            r_boundary <= 1'b0;
            r_rx_shift <= '0;
        end else if (w_bit_rise) begin
            r_rx_shift <= w_rx_next;
            if (w_byte_done) begin
                r_bit_cnt  <= '0;
                r_boundary <= 1'b1;
            end else begin
                r_bit_cnt  <= r_bit_cnt + c_CNT_ONE;
            end
        end else if (w_bit_fall) begin
            r_boundary <= 1'b0;
        end
    end

    // Transmit shifter: load on frame start or the first SCK fall after a
    // byte boundary, otherwise shift left on each SCK fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_shift <= '0;
        end else if (w_load) begin
            r_tx_shift <= r_hold_full ? r_hold : '0;
        end else if (w_frame_end) begin
            r_tx_shift <= '0;
        end else if (w_bit_fall) begin
            r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
        end
    end

    // Transmit holding register: a load consumes the old contents while a
    // same-cycle write (only possible when empty) refills it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else begin
            if (w_hold_wr) begin
                r_hold      <= tx_data;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    // Receive output register; a fresh capture wins over a consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else if (w_rx_accept) begin
            r_rx_data  <= w_rx_next;
            r_rx_valid <= 1'b1;
        end else if (r_rx_valid && rx_ready) begin
            r_rx_valid <= 1'b0;
        end
    end

    // Sticky error flags; a set event in the same cycle overrides a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_overrun  <= 1'b0;
            r_tx_underrun <= 1'b0;
        end else begin
            if (w_rx_drop) begin
                r_rx_overrun <= 1'b1;
            end else if (status_clr) begin
                r_rx_overrun <= 1'b0;
            end
            if (w_underrun_evt) begin
                r_tx_underrun <= 1'b1;
            end else if (status_clr) begin
                r_tx_underrun <= 1'b0;
            end
        end
    end

    assign spi_miso_oe = w_busy;
    assign busy        = w_busy;
    assign spi_miso    = w_busy & r_tx_shift[DATA_W-1];
    assign tx_ready    = ~r_hold_full;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign rx_overrun  = r_rx_overrun;
    assign tx_underrun = r_tx_underrun;

endmodule
`default_nettype wire

// File: tb/tb_spi_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_spi_responder
//  Description : Directed self-checking bench for spi_responder, acting as a
//                mode-0 SPI controller with hand-computed expected bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_responder;

    localparam int c_HALF = 6;   // SCK half period in clk cycles

    logic       clk;
    logic       rst_n;
    logic       spi_sck;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_overrun;
    logic       tx_underrun;
    logic       status_clr;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    int rx_pulses = 0;
    logic r_rx_prev = 1'b0;

    spi_responder #(
        .DATA_W      (8),
        .SYNC_STAGES (2)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_sck     (spi_sck),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_overrun  (rx_overrun),
        .tx_underrun (tx_underrun),
        .status_clr  (status_clr),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // count rx_valid rising edges
    always @(negedge clk) begin
        if (rx_valid && !r_rx_prev) rx_pulses++;
        r_rx_prev = rx_valid;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_tx(input logic [7:0] d);
        int k = 0;
        while (!tx_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_eq("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic pulse_rx_ready();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_clr();
        status_clr = 1'b1;
        @(negedge clk);
        status_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        wait_clks(c_HALF);
    endtask

    task automatic cs_high();
        wait_clks(c_HALF);
        spi_cs_n = 1'b1;
        wait_clks(c_HALF);
    endtask

    // controller side: present MOSI, sample MISO just before the rising edge
    task automatic spi_xfer(input logic [7:0] d, input int nbits, output logic [7:0] q);
        q = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = d[7-i];
            wait_clks(c_HALF);
            q = {q[6:0], spi_miso};
            spi_sck = 1'b1;
            wait_clks(c_HALF);
            spi_sck = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] q1;
        logic [7:0] q2;
        int         p0;

        rst_n      = 1'b0;
        spi_sck    = 1'b0;
        spi_cs_n   = 1'b1;
        spi_mosi   = 1'b0;
        tx_data    = 8'h00;
        tx_valid   = 1'b0;
        rx_ready   = 1'b0;
        status_clr = 1'b0;
        wait_clks(3);

        // reset values
        check_eq("rst_miso",     {31'd0, spi_miso},    32'd0);
        check_eq("rst_oe",       {31'd0, spi_miso_oe}, 32'd0);
        check_eq("rst_tx_ready", {31'd0, tx_ready},    32'd1);
        check_eq("rst_rx_valid", {31'd0, rx_valid},    32'd0);
        check_eq("rst_rx_data",  {24'd0, rx_data},     32'h00);
        check_eq("rst_flags",    {30'd0, rx_overrun, tx_underrun}, 32'd0);
        check_eq("rst_busy",     {31'd0, busy},        32'd0);
        rst_n = 1'b1;
        wait_clks(5);
        check_eq("post_rst_busy", {31'd0, busy}, 32'd0);

        // single byte: send A5 while receiving 3C
        write_tx(8'hA5);
        check_eq("hold_full_ready", {31'd0, tx_ready}, 32'd0);
        cs_low();
        check_eq("b1_busy",     {31'd0, busy},        32'd1);
        check_eq("b1_oe",       {31'd0, spi_miso_oe}, 32'd1);
        check_eq("b1_ready",    {31'd0, tx_ready},    32'd1);
        check_eq("b1_miso_msb", {31'd0, spi_miso},    32'd1);
        spi_xfer(8'h3C, 8, q1);
        check_eq("b1_miso_byte", {24'd0, q1},       32'hA5);
        check_eq("b1_rx_valid",  {31'd0, rx_valid}, 32'd1);
        check_eq("b1_rx_data",   {24'd0, rx_data},  32'h3C);
        check_eq("b1_overrun",   {31'd0, rx_overrun}, 32'd0);
        pulse_rx_ready();
        check_eq("b1_consumed",  {31'd0, rx_valid}, 32'd0);
        cs_high();
        check_eq("b1_oe_off",    {31'd0, spi_miso_oe}, 32'd0);
        check_eq("b1_busy_off",  {31'd0, busy},        32'd0);
        check_eq("b1_miso_off",  {31'd0, spi_miso},    32'd0);
        pulse_clr();

        // two bytes in one frame, rx_ready held high; 0x33 refills the
        // holding register so the trailing SCK fall does not underrun
        rx_ready = 1'b1;
        write_tx(8'h11);
        p0 = rx_pulses;
        cs_low();
        write_tx(8'h22);
        spi_xfer(8'h5A, 8, q1);
        write_tx(8'h33);
        spi_xfer(8'hC3, 8, q2);
        cs_high();
        rx_ready = 1'b0;
        check_eq("bb_miso0",    {24'd0, q1}, 32'h11);
        check_eq("bb_miso1",    {24'd0, q2}, 32'h22);
        check_eq("bb_pulses",   rx_pulses - p0, 32'd2);
        check_eq("bb_rx_data",  {24'd0, rx_data},  32'hC3);
        check_eq("bb_rx_valid", {31'd0, rx_valid}, 32'd0);
        check_eq("bb_overrun",  {31'd0, rx_overrun},  32'd0);
        check_eq("bb_underrun", {31'd0, tx_underrun}, 32'd0);

        // underrun: holding register empty at CS fall
        check_eq("ur_empty", {31'd0, tx_ready}, 32'd1);
        cs_low();
        check_eq("ur_flag",  {31'd0, tx_underrun}, 32'd1);
        spi_xfer(8'h00, 8, q1);
        check_eq("ur_miso",  {24'd0, q1}, 32'h00);
        cs_high();
        pulse_clr();
        check_eq("ur_clr",   {31'd0, tx_underrun}, 32'd0);
        pulse_rx_ready();

        // overrun: two bytes with rx_ready low
        cs_low();
        spi_xfer(8'h96, 8, q1);
        spi_xfer(8'h69, 8, q1);
        cs_high();
        check_eq("ov_rx_data",  {24'd0, rx_data},    32'h96);
        check_eq("ov_rx_valid", {31'd0, rx_valid},   32'd1);
        check_eq("ov_flag",     {31'd0, rx_overrun}, 32'd1);
        pulse_clr();
        check_eq("ov_clr",      {31'd0, rx_overrun}, 32'd0);
        pulse_rx_ready();
        check_eq("ov_consumed", {31'd0, rx_valid},   32'd0);

        // CS raised after 5 bits
        write_tx(8'hF0);
        cs_low();
        spi_xfer(8'h0F, 5, q1);
        check_eq("sh_miso_bits", {24'd0, q1}, 32'h1E);
        cs_high();
        check_eq("sh_rx_valid", {31'd0, rx_valid},    32'd0);
        check_eq("sh_busy",     {31'd0, busy},        32'd0);
        check_eq("sh_oe",       {31'd0, spi_miso_oe}, 32'd0);
        check_eq("sh_miso",     {31'd0, spi_miso},    32'd0);
        check_eq("sh_overrun",  {31'd0, rx_overrun},  32'd0);
        write_tx(8'hE7);
        cs_low();
        spi_xfer(8'h81, 8, q1);
        check_eq("sh_next_miso",  {24'd0, q1},       32'hE7);
        check_eq("sh_next_rx",    {24'd0, rx_data},  32'h81);
        check_eq("sh_next_valid", {31'd0, rx_valid}, 32'd1);
        cs_high();
        pulse_rx_ready();
        pulse_clr();

        // reset mid-frame with CS held low
        write_tx(8'h12);
        cs_low();
        spi_xfer(8'hFF, 4, q1);
        rst_n = 1'b0;
        #1;
        check_eq("mr_busy",     {31'd0, busy},        32'd0);
        check_eq("mr_oe",       {31'd0, spi_miso_oe}, 32'd0);
        check_eq("mr_miso",     {31'd0, spi_miso},    32'd0);
        check_eq("mr_tx_ready", {31'd0, tx_ready},    32'd1);
        check_eq("mr_rx_data",  {24'd0, rx_data},     32'h00);
        check_eq("mr_rx_valid", {31'd0, rx_valid},    32'd0);
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(4);
        spi_xfer(8'hFF, 8, q1);
        check_eq("mr_no_start", {31'd0, busy},     32'd0);
        check_eq("mr_no_rx",    {31'd0, rx_valid}, 32'd0);
        spi_cs_n = 1'b1;
        wait_clks(c_HALF);
        write_tx(8'h4B);
        cs_low();
        check_eq("mr_restart", {31'd0, busy}, 32'd1);
        spi_xfer(8'hA9, 8, q1);
        check_eq("mr_miso_byte", {24'd0, q1},      32'h4B);
        check_eq("mr_rx_byte",   {24'd0, rx_data}, 32'hA9);
        cs_high();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_responder.md
SPI_RESPONDER -- requirements
Module: spi_responder

Interface
REQ-001 Parameter DATA_W, default 8, frame width in bits.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth on spi_sck, spi_cs_n and spi_mosi.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 spi_sck  input  1  SPI clock from the SoC SPI controller, mode 0 (CPOL=0, CPHA=0).
REQ-006 spi_cs_n  input  1  chip select, active-low.
REQ-007 spi_mosi  input  1  serial data from the controller, MSB first.
REQ-008 spi_miso  output  1  serial data to the controller, MSB first.
REQ-009 spi_miso_oe  output  1  MISO drive enable; high only while the frame is selected.
REQ-010 tx_data  input  DATA_W  next byte to transmit.
REQ-011 tx_valid  input  1  tx_data valid.
REQ-012 tx_ready  output  1  transmit holding register empty.
REQ-013 rx_data  output  DATA_W  last received byte.
REQ-014 rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-015 rx_ready  input  1  consumer accepts rx_data.
REQ-016 rx_overrun  output  1  sticky: a byte completed while rx_valid was high.
REQ-017 tx_underrun  output  1  sticky: a byte load found the holding register empty.
REQ-018 status_clr  input  1  clears both sticky flags.
REQ-019 busy  output  1  high while in SHIFT state.

Function
REQ-020 The block SHALL register spi_sck, spi_cs_n and spi_mosi through SYNC_STAGES flops, then detect edges against one further registered copy.
REQ-021 Input timing: spi_sck high and low phases SHALL each be at least 3 clk periods; faster SCK is outside the operating range.
REQ-022 Control SHALL have two states: IDLE and SHIFT.
REQ-023 IDLE -> SHIFT on a detected falling edge of synchronized spi_cs_n: load the shifter from the holding register, clear the bit counter, assert spi_miso_oe.
REQ-024 SHIFT -> IDLE on a detected rising edge of synchronized spi_cs_n, from any bit count.
REQ-025 spi_miso SHALL equal the shifter MSB; it SHALL be 0 whenever spi_miso_oe is low.
REQ-026 On each detected spi_sck rising edge in SHIFT, the block SHALL shift synchronized spi_mosi into the receive shifter LSB and increment the bit counter.
REQ-027 On each detected spi_sck falling edge in SHIFT, the transmit shifter SHALL shift left by one, except after a byte boundary, where it SHALL load the next byte (REQ-030) instead.
REQ-028 Bit counter: width clog2(DATA_W); wraps to 0 on the DATA_W-th rising edge, which marks a byte boundary.
REQ-029 At a byte boundary: if rx_valid is low, or rx_ready is high in that cycle, capture the receive shifter (including the bit just sampled) into rx_data and set rx_valid; otherwise discard the byte and set rx_overrun.
REQ-030 A load (CS falling edge or first falling SCK edge after a boundary) SHALL take tx_data from the holding register and empty it; if empty, load all-zeros and set tx_underrun.
REQ-031 Holding register: tx_ready = empty; tx_valid && tx_ready captures tx_data. On a simultaneous load and write, the load sees the old contents (empty -> underrun) and the write is captured.
REQ-032 rx_valid SHALL clear on rx_valid && rx_ready unless a new byte is captured in the same cycle (REQ-029), in which case it stays high with the new data.
REQ-033 CS deassertion mid-byte SHALL discard the partial receive byte (no rx_valid, no overrun); the partially sent transmit byte is not resent.
REQ-034 If status_clr and a flag-set event coincide, set SHALL win.
REQ-035 Latency: rx_valid asserts, and spi_miso changes, SYNC_STAGES+1 clk cycles after the corresponding pin edge.
REQ-036 The block SHALL ignore spi_sck edges while in IDLE.

Reset
REQ-037 When rst_n is low: state IDLE, counters and shifters 0, holding register empty, spi_miso=0, spi_miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, rx_overrun=0, tx_underrun=0, busy=0.
REQ-038 Reset asserted mid-frame SHALL abort the frame immediately. After release, the block SHALL wait for a fresh spi_cs_n falling edge; a CS already low at release SHALL NOT start a frame.

Verification
REQ-039 Preload 0xA5, CS low, send 0x3C over 8 SCK cycles -> MISO bits 1,0,1,0,0,1,0,1; rx_data=0x3C, rx_valid=1; tx_ready=1 after the load.
REQ-040 Two back-to-back bytes in one CS frame, with 0x11 then 0x22 loaded and rx_ready held high -> MISO 0x11 then 0x22; rx_valid pulses once per byte; no flags set.
REQ-041 Empty holding register at CS fall -> MISO 0x00 and tx_underrun=1; status_clr pulse -> tx_underrun=0.
REQ-042 rx_ready held low for two full bytes -> rx_data keeps the first byte, rx_overrun=1.
REQ-043 CS raised after 5 bits -> rx_valid stays 0, state IDLE, spi_miso_oe=0; the next full frame is received correctly.
REQ-044 rst_n pulsed low at bit 4 with CS held low -> all outputs at reset values; no frame starts until CS toggles high then low.
